rf_cmd_bridge: RTL and testbench
================================

# rf_cmd_bridge

Upstream command front-end for the generated register-file blocks (e.g. ramRF). Accepts single read/write commands from a host over a valid/ready channel and drives the RF software port (address, read_en/write_en strobes, write_data). Waits for access_complete, then returns read data and status over a valid/ready response channel. Adds a bounded wait (timeout) and a saturating error counter, so a hung or invalid RF access never stalls the host.

## Interface
Parameters:
- ADDR_WIDTH, 5, RF word-address width (RF address[7:3])
- DATA_WIDTH, 64, RF data width
- TIMEOUT, 255, maximum cycles to wait for access_complete after the strobe (1..65535)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- res  in  1  synchronous active-high reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  bridge accepts command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  word address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  host takes response
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and error responses)
- rsp_error  out  1  RF flagged invalid_address
- rsp_timeout  out  1  no access_complete within TIMEOUT
- err_count  out  8  saturating count of error or timeout responses
- rf_address  out  ADDR_WIDTH  to RF address
- rf_read_en  out  1  RF read strobe
- rf_write_en  out  1  RF write strobe
- rf_write_data  out  DATA_WIDTH  to RF write_data
- rf_read_data  in  DATA_WIDTH  from RF read_data
- rf_invalid_address  in  1  from RF
- rf_access_complete  in  1  from RF

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1 (forced 0 while res = 1).
  - On cmd_valid & cmd_ready: register cmd_write, cmd_addr and cmd_wdata into rf_address/rf_write_data, then go to ISSUE.
- ISSUE:
  - Exactly one cycle. rf_write_en = cmd_write and rf_read_en = !cmd_write; never both.
  - Wait counter = 0.
  - rf_access_complete is sampled this cycle. If high, capture the result and go to RESP; else go to WAIT.
- WAIT:
  - Strobes low. rf_address and rf_write_data stay held. Counter increments each cycle.
  - rf_access_complete high: capture the result, go to RESP.
  - Counter reaches TIMEOUT without completion: rsp_timeout = 1, rsp_error = 0, rsp_rdata = 0, go to RESP.
- Capture on completion:
  - rsp_rdata = rf_read_data for reads, 0 for writes.
  - rsp_error = rf_invalid_address; when it is 1, rsp_rdata = 0.
  - rsp_timeout = 0.
- RESP:
  - rsp_valid = 1; all rsp_* stay stable until rsp_ready is high.
  - On the handshake edge go to IDLE and drop rsp_valid.
- err_count increments by 1 at each RESP entry with rsp_error | rsp_timeout, saturating at 255. It is cleared only by res.
- rf_access_complete outside ISSUE/WAIT is ignored.
- Reset values: state IDLE; cmd_ready 0 during reset, 1 on the first cycle after res deasserts. rsp_valid, rsp_rdata, rsp_error, rsp_timeout, err_count, rf_address, rf_read_en, rf_write_en and rf_write_data are all 0.
- Reset mid-transaction:
  - The transaction is abandoned and no response is produced.
  - Strobes are low from the next cycle.
  - An RF write already strobed is not undone.

## Timing
- Command accepted at edge N; strobe high during cycle N+1.
- Completion in the strobe cycle: rsp_valid at N+2. Completion k cycles after the strobe: rsp_valid at N+2+k.
- Timeout:
  - Completion is accepted up to TIMEOUT cycles after the strobe cycle.
  - If none arrives, rsp_valid with rsp_timeout at N+2+TIMEOUT.
- Response taken at edge M (rsp_ready high): cmd_ready high at M+1, next strobe no earlier than M+2.
- Peak throughput: one command per 3 cycles.
- Strobes are single-cycle pulses; the bridge never re-strobes while waiting.

## Test plan
- Reset then write: cmd addr 3, wdata 0x1234, write.
  - rf_write_en high for one cycle with rf_address 3 and rf_write_data 0x1234.
  - rsp_valid 2 cycles after accept, with rsp_rdata 0 and error/timeout 0.
- Read with access_complete delayed 4 cycles, rf_read_data 0xDEADBEEF.
  - rf_read_en pulses exactly once.
  - rsp_rdata 0xDEADBEEF at accept+6.
- Fill and check: 32 writes of data = i to addresses 0..31 on a ramRF model, then 32 reads.
  - Every rsp_rdata = i.
  - No error; err_count stays 0.
- Invalid address, then timeout (TIMEOUT = 8):
  - Invalid address: rf_invalid_address with completion gives rsp_error 1, rsp_rdata 0.
  - Timeout: completion never asserted gives rsp_timeout at accept+10.
  - err_count = 2.
- Backpressure: hold rsp_ready low 5 cycles with cmd_valid high.
  - Response fields stay stable and cmd_ready stays 0.
  - Second command accepted the cycle after rsp_ready.
- Reset asserted in WAIT:
  - Next cycle all outputs are at reset values and no rsp_valid appears.
  - err_count 0; the next command completes normally.

Source files
------------

// File: rtl/rf_cmd_bridge.sv
// rf_cmd_bridge
// Host-side command front-end for a generated register file (e.g. ramRF).
// Takes one read/write command at a time over a valid/ready channel, pulses the
// RF software-port strobe for one cycle, and waits for access_complete. It then
// returns read data and status over a valid/ready response channel. A bounded
// wait turns a missing completion into a timeout response, so a hung RF never
// stalls the host. A saturating counter tallies error and timeout responses.
//
// Ports:
//   clk, res                  clock; synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_write                 1 = write, 0 = read
//   cmd_addr, cmd_wdata       command word address / write data
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata                 read data (0 for writes and error/timeout responses)
//   rsp_error                 RF flagged invalid_address
//   rsp_timeout               no access_complete within TIMEOUT cycles
//   err_count                 saturating count of error/timeout responses
//   rf_address, rf_read_en, rf_write_en, rf_write_data   RF software port (driven)
//   rf_read_data, rf_invalid_address, rf_access_complete RF software port (sampled)

module rf_cmd_bridge #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic                  rf_read_en,
    output logic                  rf_write_en,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    input  logic                  rf_invalid_address,
    input  logic                  rf_access_complete
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int              CW     = 16;
    localparam logic [CW-1:0]   TO_LIM = CW'(TIMEOUT);

    logic [1:0]            state_q,     state_d;
    logic                  write_q,     write_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic                  rd_en_q,     rd_en_d;
    logic                  wr_en_q,     wr_en_d;
    logic [CW-1:0]         cnt_q,       cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
    logic                  err_q,       err_d;
    logic                  tmo_q,       tmo_d;
    logic [7:0]            errcnt_q,    errcnt_d;

    logic accept;

    assign cmd_ready = (state_q == S_IDLE) && !res;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        errcnt_d    = errcnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    // Strobes are registered so they are glitch-free one-cycle pulses in ISSUE.
                    wr_en_d = cmd_write;
                    rd_en_d = !cmd_write;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (rf_access_complete) begin
                    rsp_valid_d = 1'b1;
                    err_d       = rf_invalid_address;
                    tmo_d       = 1'b0;
                    rdata_d     = (write_q || rf_invalid_address) ? '0 : rf_read_data;
                    if (rf_invalid_address && errcnt_q != 8'hFF) begin
                        errcnt_d = errcnt_q + 8'd1;
                    end
                    state_d = S_RESP;
                end else if (state_q == S_ISSUE) begin
                    // cnt holds how many cycles after the strobe cycle the current cycle is.
                    cnt_d   = CW'(1);
                    state_d = S_WAIT;
                end else if (cnt_q >= TO_LIM) begin
                    rsp_valid_d = 1'b1;
                    err_d       = 1'b0;
                    tmo_d       = 1'b1;
                    rdata_d     = '0;
                    if (errcnt_q != 8'hFF) begin
                        errcnt_d = errcnt_q + 8'd1;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            errcnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            errcnt_q    <= errcnt_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_error     = err_q;
    assign rsp_timeout   = tmo_q;
    assign err_count     = errcnt_q;
    assign rf_address    = addr_q;
    assign rf_read_en    = rd_en_q;
    assign rf_write_en   = wr_en_q;
    assign rf_write_data = wdata_q;

endmodule

// File: tb/tb_rf_cmd_bridge.sv
// Directed bench for rf_cmd_bridge with a behavioural ramRF model and a
// response scoreboard.

module tb_rf_cmd_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        res;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_addr;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [7:0]  err_count;
    logic [4:0]  rf_address;
    logic        rf_read_en;
    logic        rf_write_en;
    logic [63:0] rf_write_data;
    logic [63:0] rf_read_data;
    logic        rf_invalid_address;
    logic        rf_access_complete;

    rf_cmd_bridge #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(64),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk), .res(res),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .err_count(err_count),
        .rf_address(rf_address), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
        .rf_invalid_address(rf_invalid_address), .rf_access_complete(rf_access_complete)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- ramRF behavioural model ----------------
    logic [63:0] mem [32];
    logic        pend = 1'b0;
    int          kcnt = 0;
    int          rf_delay = 0;
    logic        rf_never = 1'b0;
    logic        rf_inv_mode = 1'b0;

    assign rf_read_data       = mem[rf_address];
    assign rf_invalid_address = rf_inv_mode;
    assign rf_access_complete = !rf_never &&
        (((rf_read_en || rf_write_en) && rf_delay == 0) || (pend && kcnt == rf_delay));

    always @(posedge clk) begin
        if (res) begin
            pend <= 1'b0;
        end else if (rf_read_en || rf_write_en) begin
            if (rf_write_en) mem[rf_address] <= rf_write_data;
            pend <= !rf_access_complete;
            kcnt <= 1;
        end else if (pend) begin
            if (rf_access_complete) pend <= 1'b0;
            kcnt <= kcnt + 1;
        end
    end

    // ---------------- strobe monitor ----------------
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [4:0]  last_wr_addr = '0;
    logic [63:0] last_wr_data = '0;

    always @(negedge clk) begin
        if (rf_read_en) rd_cnt = rd_cnt + 1;
        if (rf_write_en) begin
            wr_cnt = wr_cnt + 1;
            last_wr_addr = rf_address;
            last_wr_data = rf_write_data;
        end
        if (rf_read_en && rf_write_en) both_cnt = both_cnt + 1;
    end

    // ---------------- scoreboard / checking ----------------
    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        tmo;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   acc_edge = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [4:0] a, input logic [63:0] d,
                            output int waited);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        @(posedge clk);
        #1;
        acc_edge  = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        check("rsp_valid_seen", 64'(rsp_valid), 64'd1);
        check("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            // Cycle labels: the cycle right after the accept edge is accept+1.
            check("rsp_latency", 64'(cyc - acc_edge + 1), 64'(e.lat));
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_error", 64'(rsp_error), 64'(e.err));
            check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
            for (int i = 0; i < hold; i++) begin
                tick();
                check("bp_valid", 64'(rsp_valid), 64'd1);
                check("bp_rdata", rsp_rdata, e.rdata);
                check("bp_error", 64'(rsp_error), 64'(e.err));
                check("bp_timeout", 64'(rsp_timeout), 64'(e.tmo));
                check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        check("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
    endtask

    task automatic push_exp(input logic [63:0] rd, input logic er, input logic tm, input int lat);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        e.tmo   = tm;
        e.lat   = lat;
        sbq.push_back(e);
    endtask

    task automatic xact(input logic wr, input logic [4:0] a, input logic [63:0] d, input int k,
                        input logic [63:0] erd, input logic eer, input logic etm);
        int w;
        rf_delay = k;
        push_exp(erd, eer, etm, etm ? 2 + TO : 2 + k);
        send_cmd(wr, a, d, w);
        check("cmd_accept_wait", 64'(w < 50), 64'd1);
        get_rsp(0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, rd0, wr0, nv;

        res = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_rf_strobes", 64'({rf_read_en, rf_write_en}), 64'd0);
        check("rst_rf_address", 64'(rf_address), 64'd0);
        res = 1'b0;
        tick();
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Single write with completion in the strobe cycle
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        xact(1'b1, 5'd3, 64'h1234, 0, 64'd0, 1'b0, 1'b0);
        check("wr_pulses", 64'(wr_cnt - wr0), 64'd1);
        check("wr_no_rd", 64'(rd_cnt - rd0), 64'd0);
        check("wr_addr", 64'(last_wr_addr), 64'd3);
        check("wr_data", last_wr_data, 64'h1234);

        // Read with completion 4 cycles after the strobe
        xact(1'b1, 5'd7, 64'hDEADBEEF, 0, 64'd0, 1'b0, 1'b0);
        rd0 = rd_cnt;
        xact(1'b0, 5'd7, 64'd0, 4, 64'hDEADBEEF, 1'b0, 1'b0);
        check("rd_pulses", 64'(rd_cnt - rd0), 64'd1);

        // Fill and check all 32 words with varied completion delays
        for (int i = 0; i < 32; i++) xact(1'b1, 5'(i), 64'(i), i % 3, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) xact(1'b0, 5'(i), 64'd0, i % 4, 64'(i), 1'b0, 1'b0);
        check("fill_err_count", 64'(err_count), 64'd0);

        // Invalid address: read data is zeroed even though the word holds 5
        rf_inv_mode = 1'b1;
        xact(1'b0, 5'd5, 64'd0, 1, 64'd0, 1'b1, 1'b0);
        rf_inv_mode = 1'b0;
        check("inv_err_count", 64'(err_count), 64'd1);

        // Completion at exactly TIMEOUT cycles is still accepted
        xact(1'b0, 5'd6, 64'd0, TO, 64'd6, 1'b0, 1'b0);

        // Timeout
        rf_never = 1'b1;
        xact(1'b0, 5'd4, 64'd0, 0, 64'd0, 1'b0, 1'b1);
        rf_never = 1'b0;
        check("to_err_count", 64'(err_count), 64'd2);

        // Backpressure: response held 5 cycles while a second command waits
        rf_delay = 0;
        push_exp(64'h11, 1'b0, 1'b0, 2);
        send_cmd(1'b0, 5'd17, 64'd0, w);
        cmd_write = 1'b1;
        cmd_addr  = 5'd20;
        cmd_wdata = 64'hCAFE;
        cmd_valid = 1'b1;
        get_rsp(5);
        push_exp(64'd0, 1'b0, 1'b0, 2);
        send_cmd(1'b1, 5'd20, 64'hCAFE, w);
        check("bp_second_accept_wait", 64'(w), 64'd0);
        get_rsp(0);
        xact(1'b0, 5'd20, 64'd0, 2, 64'hCAFE, 1'b0, 1'b0);

        // Reset while in WAIT
        rf_never = 1'b1;
        rd0 = rd_cnt;
        send_cmd(1'b0, 5'd2, 64'd0, w);
        repeat (3) tick();
        check("wait_rd_pulses", 64'(rd_cnt - rd0), 64'd1);
        res = 1'b1;
        tick();
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_strobes", 64'({rf_read_en, rf_write_en}), 64'd0);
        check("mid_rst_err_count", 64'(err_count), 64'd0);
        check("mid_rst_rf_address", 64'(rf_address), 64'd0);
        check("mid_rst_rsp_flags", 64'({rsp_error, rsp_timeout}), 64'd0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        res = 1'b0;
        rf_never = 1'b0;
        tick();
        check("mid_rst_cmd_ready_after", 64'(cmd_ready), 64'd1);
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid) nv++;
        end
        check("mid_rst_no_rsp", 64'(nv), 64'd0);
        xact(1'b1, 5'd9, 64'hABC, 1, 64'd0, 1'b0, 1'b0);
        xact(1'b0, 5'd9, 64'd0, 0, 64'hABC, 1'b0, 1'b0);
        check("final_err_count", 64'(err_count), 64'd0);

        check("never_both_strobes", 64'(both_cnt), 64'd0);
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
